// File: rtl/wb_interconnect_arb.sv
// Shared-bus Wishbone interconnect: NUMM masters, NUMS slaves, fixed or round-robin arbitration,
// internal error responder for unmapped addresses and a per-access watchdog.
module wb_interconnect_arb #(
    parameter int unsigned             NUMM      = 2,
    parameter int unsigned             NUMS      = 5,
    parameter logic [NUMS-1:0][31:0]   BASE_ADDR = '0,
    parameter logic [NUMS-1:0][31:0]   SIZE      = {NUMS{32'h10}},
    parameter int unsigned             ARB_MODE  = 1,
    parameter int unsigned             TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    // master side
    input  logic [NUMM-1:0]            wbm_cyc,
    input  logic [NUMM-1:0]            wbm_stb,
    input  logic [NUMM-1:0]            wbm_we,
    input  logic [NUMM-1:0][3:0]       wbm_sel,
    input  logic [NUMM-1:0][31:0]      wbm_adr,
    input  logic [NUMM-1:0][31:0]      wbm_dat_m,
    output logic [NUMM-1:0][31:0]      wbm_dat_s,
    output logic [NUMM-1:0]            wbm_ack,
    output logic [NUMM-1:0]            wbm_err,
    // slave side
    output logic [NUMS-1:0]            wbs_cyc,
    output logic [NUMS-1:0]            wbs_stb,
    output logic [NUMS-1:0]            wbs_we,
    output logic [NUMS-1:0][3:0]       wbs_sel,
    output logic [NUMS-1:0][31:0]      wbs_adr,
    output logic [NUMS-1:0][31:0]      wbs_dat_m,
    input  logic [NUMS-1:0][31:0]      wbs_dat_s,
    input  logic [NUMS-1:0]            wbs_ack,
    input  logic [NUMS-1:0]            wbs_err,
    output logic [NUMM-1:0]            gnt_o,
    output logic                       tmo_o
);

    localparam int unsigned MW = (NUMM > 1) ? $clog2(NUMM) : 1;
    localparam int unsigned SW = (NUMS > 1) ? $clog2(NUMS) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [MW-1:0] LAST_M   = MW'(NUMM - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [NUMM-1:0]   gnt_q, gnt_d;
    logic [MW-1:0]     gidx_q, gidx_d;
    logic [MW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              err_q, err_d;

    logic              in_grant;
    logic              m_cyc, m_stb, m_we;
    logic [3:0]        m_sel;
    logic [31:0]       m_adr, m_dat;

    logic [MW-1:0]     win_idx;
    logic [NUMS-1:0]   hit;
    logic [SW-1:0]     hit_idx;
    logic              nohit;
    logic              slv_act;
    logic              s_ack, s_err;
    logic [31:0]       s_dat;

    assign in_grant = (state_q == StGrant);
    assign m_cyc    = wbm_cyc[gidx_q];
    assign m_stb    = wbm_stb[gidx_q];
    assign m_we     = wbm_we[gidx_q];
    assign m_sel    = wbm_sel[gidx_q];
    assign m_adr    = wbm_adr[gidx_q];
    assign m_dat    = wbm_dat_m[gidx_q];

    // Winner among current requesters; fixed mode scans from 0, RR mode from the pointer.
    always_comb begin
        int unsigned cand;
        logic        found;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUMM; k++) begin
            if (ARB_MODE == 0) begin
                cand = k;
            end else begin
                cand = (int'(rr_q) + k) % NUMM;
            end
            if (!found && wbm_cyc[MW'(cand)]) begin
                found   = 1'b1;
                win_idx = MW'(cand);
            end
        end
    end

    // Address decode; unsigned offset compare excludes wrap-around, lowest index wins.
    always_comb begin
        logic found;
        hit     = '0;
        hit_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < NUMS; j++) begin
            if (!found && ((m_adr - BASE_ADDR[j]) < SIZE[j])) begin
                found   = 1'b1;
                hit[j]  = 1'b1;
                hit_idx = SW'(j);
            end
        end
    end

    assign nohit   = ~|hit;
    // Slave strobe is suppressed during the watchdog err cycle.
    assign slv_act = in_grant & m_cyc & m_stb & ~nohit & ~tmo_q;
    assign s_ack   = wbs_ack[hit_idx] & slv_act;
    assign s_err   = wbs_err[hit_idx] & slv_act;
    assign s_dat   = nohit ? 32'h0 : wbs_dat_s[hit_idx];

    assign err_d   = in_grant & m_cyc & m_stb & nohit & ~err_q;

    always_comb begin
        cnt_d = '0;
        tmo_d = 1'b0;
        if (TIMEOUT != 0 && slv_act && !s_ack && !s_err) begin
            if (cnt_q == CNT_LAST) begin
                tmo_d = 1'b1;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (|wbm_cyc) begin
                    state_d        = StGrant;
                    gidx_d         = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                end
            end
            StGrant: begin
                if (!m_cyc) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    rr_d    = (gidx_q == LAST_M) ? '0 : gidx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wbs_cyc   = '0;
        wbs_stb   = '0;
        wbs_we    = '0;
        wbs_sel   = '0;
        wbs_adr   = '0;
        wbs_dat_m = '0;
        if (in_grant) begin
            for (int j = 0; j < NUMS; j++) begin
                wbs_cyc[j]   = m_cyc;
                wbs_stb[j]   = hit[j] & slv_act;
                wbs_we[j]    = m_we;
                wbs_sel[j]   = m_sel;
                wbs_adr[j]   = m_adr;
                wbs_dat_m[j] = m_dat;
            end
        end
    end

    always_comb begin
        wbm_ack   = '0;
        wbm_err   = '0;
        wbm_dat_s = '0;
        for (int i = 0; i < NUMM; i++) begin
            if (in_grant && gidx_q == MW'(i)) begin
                wbm_ack[i]   = s_ack;
                wbm_err[i]   = s_err | err_q | tmo_q;
                wbm_dat_s[i] = s_dat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o = gnt_q;
    assign tmo_o = tmo_q;

endmodule

// File: tb/tb_wb_interconnect_arb.sv
// Directed bench: a round-robin and a fixed-priority interconnect driven by the same masters,
// each with its own simple slave models (slave 4 never acks).
module tb_wb_interconnect_arb;

    localparam logic [4:0][31:0] BASE  = {32'h1000_0030, 32'h1000_0020, 32'h1000_0010,
                                          32'h1000_0000, 32'h0000_0000};
    localparam logic [4:0][31:0] SIZES = {32'h10, 32'h10, 32'h10, 32'h10, 32'h0001_0000};
    localparam logic [4:0]       HANG  = 5'b10000;

    // Contention vectors: bit0 = master 0 cyc/stb, bit1 = master 1 cyc/stb.
    localparam logic [1:0] CYC_V  [15] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11,
                                           2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
    localparam logic [1:0] EXP_RR [15] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01,
                                           2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    localparam logic [1:0] EXP_FX [15] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01,
                                           2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};

    logic clk, rst;
    logic [1:0]       m_cyc, m_stb, m_we;
    logic [1:0][3:0]  m_sel;
    logic [1:0][31:0] m_adr, m_dat;
    logic [4:0]       rogue;

    logic [1:0][31:0] rr_mdat_s, fx_mdat_s;
    logic [1:0]       rr_mack, rr_merr, fx_mack, fx_merr, rr_gnt, fx_gnt;
    logic [4:0]       rr_scyc, rr_sstb, rr_swe, rr_sack, rr_serr;
    logic [4:0]       fx_scyc, fx_sstb, fx_swe, fx_sack, fx_serr;
    logic [4:0][3:0]  rr_ssel, fx_ssel;
    logic [4:0][31:0] rr_sadr, rr_sdat_m, rr_sdat_s, rr_mem;
    logic [4:0][31:0] fx_sadr, fx_sdat_m, fx_sdat_s, fx_mem;
    logic             rr_tmo, fx_tmo;

    int n_checks = 0;
    int n_errors = 0;

    wb_interconnect_arb #(.NUMM(2), .NUMS(5), .BASE_ADDR(BASE), .SIZE(SIZES),
                          .ARB_MODE(1), .TIMEOUT(8)) dut_rr (
        .clk(clk), .rst(rst),
        .wbm_cyc(m_cyc), .wbm_stb(m_stb), .wbm_we(m_we), .wbm_sel(m_sel), .wbm_adr(m_adr),
        .wbm_dat_m(m_dat), .wbm_dat_s(rr_mdat_s), .wbm_ack(rr_mack), .wbm_err(rr_merr),
        .wbs_cyc(rr_scyc), .wbs_stb(rr_sstb), .wbs_we(rr_swe), .wbs_sel(rr_ssel),
        .wbs_adr(rr_sadr), .wbs_dat_m(rr_sdat_m), .wbs_dat_s(rr_sdat_s), .wbs_ack(rr_sack),
        .wbs_err(rr_serr), .gnt_o(rr_gnt), .tmo_o(rr_tmo)
    );

    wb_interconnect_arb #(.NUMM(2), .NUMS(5), .BASE_ADDR(BASE), .SIZE(SIZES),
                          .ARB_MODE(0), .TIMEOUT(8)) dut_fx (
        .clk(clk), .rst(rst),
        .wbm_cyc(m_cyc), .wbm_stb(m_stb), .wbm_we(m_we), .wbm_sel(m_sel), .wbm_adr(m_adr),
        .wbm_dat_m(m_dat), .wbm_dat_s(fx_mdat_s), .wbm_ack(fx_mack), .wbm_err(fx_merr),
        .wbs_cyc(fx_scyc), .wbs_stb(fx_sstb), .wbs_we(fx_swe), .wbs_sel(fx_ssel),
        .wbs_adr(fx_sadr), .wbs_dat_m(fx_sdat_m), .wbs_dat_s(fx_sdat_s), .wbs_ack(fx_sack),
        .wbs_err(fx_serr), .gnt_o(fx_gnt), .tmo_o(fx_tmo)
    );

    // Zero-wait slaves; rogue lets slave acks appear without a strobe.
    assign rr_sack   = (rr_sstb & rr_scyc & ~HANG) | rogue;
    assign fx_sack   = fx_sstb & fx_scyc & ~HANG;
    assign rr_serr   = '0;
    assign fx_serr   = '0;
    assign rr_sdat_s = rr_mem;
    assign fx_sdat_s = fx_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_mem <= '0;
            fx_mem <= '0;
        end else begin
            for (int j = 0; j < 5; j++) begin
                for (int b = 0; b < 4; b++) begin
                    if (rr_sack[j] && rr_swe[j] && rr_ssel[j][b])
                        rr_mem[j][8*b +: 8] <= rr_sdat_m[j][8*b +: 8];
                    if (fx_sack[j] && fx_swe[j] && fx_ssel[j][b])
                        fx_mem[j][8*b +: 8] <= fx_sdat_m[j][8*b +: 8];
                end
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        rogue = '0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst   = 1'b1;
        rogue = '0;
        m_sel = {4'hF, 4'hF};
        m_we  = '0;
        m_dat = {32'h2222_2222, 32'hDEAD_BEEF};
        m_adr = {32'h1000_0000, 32'h1000_0000};
        m_cyc = 2'b01;
        m_stb = 2'b01;
        step();
        step();
        settle();
        check("rst gnt", 32'(rr_gnt), 0);
        check("rst tmo", 32'(rr_tmo), 0);
        check("rst sstb", 32'(rr_sstb), 0);
        check("rst scyc", 32'(rr_scyc), 0);
        check("rst ack", 32'(rr_mack), 0);
        check("rst err", 32'(rr_merr), 0);
        check("rst dat_s", rr_mdat_s[0], 0);
        check("rst fx gnt", 32'(fx_gnt), 0);

        // Single-master write then read-back on GPIO0 (slave 1).
        do_reset();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_we  = 2'b01;
        settle();
        check("wr gnt idle", 32'(rr_gnt), 0);
        check("wr sstb idle", 32'(rr_sstb), 0);
        step();
        settle();
        check("wr gnt", 32'(rr_gnt), 32'h1);
        check("wr sstb", 32'(rr_sstb), 32'h02);
        check("wr ack", 32'(rr_mack), 32'h1);
        check("wr sadr", rr_sadr[1], 32'h1000_0000);
        check("wr sdat", rr_sdat_m[1], 32'hDEAD_BEEF);
        check("wr fx ack", 32'(fx_mack), 32'h1);
        check("wr fx sadr", fx_sadr[1], 32'h1000_0000);
        step();
        m_we = 2'b00;
        settle();
        check("rd ack", 32'(rr_mack), 32'h1);
        check("rd dat", rr_mdat_s[0], 32'hDEAD_BEEF);
        check("rd fx dat", fx_mdat_s[0], 32'hDEAD_BEEF);
        step();
        m_cyc = '0;
        m_stb = '0;

        // Contention: both DUTs see identical master traffic.
        do_reset();
        m_we = 2'b11;
        for (int c = 0; c < 15; c++) begin
            m_cyc = CYC_V[c];
            m_stb = CYC_V[c];
            settle();
            check($sformatf("rr gnt c%0d", c), 32'(rr_gnt), 32'(EXP_RR[c]));
            check($sformatf("fx gnt c%0d", c), 32'(fx_gnt), 32'(EXP_FX[c]));
            check($sformatf("rr ack c%0d", c), 32'(rr_mack), 32'(EXP_RR[c] & CYC_V[c]));
            step();
        end

        // Unmapped read.
        do_reset();
        m_adr[0] = 32'h2000_0000;
        m_cyc    = 2'b01;
        m_stb    = 2'b01;
        m_we     = 2'b00;
        step();
        settle();
        check("um err c1", 32'(rr_merr), 0);
        check("um sstb c1", 32'(rr_sstb), 0);
        step();
        settle();
        check("um err c2", 32'(rr_merr), 32'h1);
        check("um sstb c2", 32'(rr_sstb), 0);
        check("um dat c2", rr_mdat_s[0], 0);
        check("um ack c2", 32'(rr_mack), 0);
        step();
        m_cyc = '0;
        m_stb = '0;
        settle();
        check("um err c3", 32'(rr_merr), 0);

        // Hung slave 4: watchdog err eight cycles after the first slave strobe.
        do_reset();
        m_adr[0] = 32'h1000_0030;
        m_cyc    = 2'b01;
        m_stb    = 2'b01;
        step();
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) rogue = 5'b10000;
            settle();
            check($sformatf("wd err k%0d", k), 32'(rr_merr[0]), 32'(k == 9));
            check($sformatf("wd tmo k%0d", k), 32'(rr_tmo), 32'(k == 9));
            check($sformatf("wd sstb k%0d", k), 32'(rr_sstb[4]), 32'(k != 9));
            check($sformatf("wd ack k%0d", k), 32'(rr_mack[0]), 0);
            check($sformatf("wd fx tmo k%0d", k), 32'(fx_tmo), 32'(k == 9));
            step();
        end
        rogue = '0;
        m_cyc = '0;
        m_stb = '0;

        // Reset during a granted access after the RR pointer has moved to 1.
        do_reset();
        m_adr[0] = 32'h1000_0000;
        m_cyc    = 2'b01;
        m_stb    = 2'b01;
        step();
        step();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        step();
        m_adr[0] = 32'h1000_0030;
        m_cyc    = 2'b01;
        m_stb    = 2'b01;
        step();
        settle();
        check("mr gnt before", 32'(rr_gnt), 32'h1);
        check("mr sstb before", 32'(rr_sstb), 32'h10);
        #1;
        rst = 1'b1;
        #1;
        check("mr gnt", 32'(rr_gnt), 0);
        check("mr sstb", 32'(rr_sstb), 0);
        check("mr ack", 32'(rr_mack), 0);
        check("mr err", 32'(rr_merr), 0);
        m_adr[1] = 32'h1000_0000;
        m_cyc    = 2'b11;
        m_stb    = 2'b11;
        step();
        rst = 1'b0;
        settle();
        check("mr gnt idle", 32'(rr_gnt), 0);
        step();
        settle();
        check("mr gnt first", 32'(rr_gnt), 32'h1);
        step();
        m_cyc = '0;
        m_stb = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_interconnect_arb.md
Name: wb_interconnect_arb

Overview:
Parametrised successor to the shared-bus Wishbone interconnect for the Ibex SoC. It connects NUMM masters to NUMS slaves over one shared bus. Arbitration is selectable: fixed-priority or round-robin. Unmapped addresses get an internal error responder, and a per-transaction watchdog terminates hung slave accesses with err. It sits between wb_ibex_core (plus the debug module when enabled) and the RAM, GPIO, UART and timer slaves.

Parameters:
- NUMM, 2, number of masters; index 0 has highest priority in fixed mode.
- NUMS, 5, number of slaves.
- BASE_ADDR, array [NUMS] of 32-bit, all 0, slave base addresses.
- SIZE, array [NUMS] of 32-bit, all 'h10, slave region sizes in bytes.
- ARB_MODE, 1, 0 = fixed priority, 1 = round-robin.
- TIMEOUT, 255, cycles a request may wait for ack/err before watchdog err; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- wbm  wb_if slave modport  [NUMM]  master-side ports; signals used: cyc, stb, we, sel[3:0], adr[31:0], dat_m[31:0], dat_s[31:0], ack, err.
- wbs  wb_if master modport  [NUMS]  slave-side ports; same signal set.
- gnt_o  output  NUMM  one-hot current grant, registered.
- tmo_o  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt_o=0, rr pointer=0, watchdog counter=0, tmo_o=0.
  - All wbs cyc/stb=0; all wbm ack/err=0, dat_s=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - Requests are wbm[i].cyc.
  - Fixed mode: the lowest-index requester wins.
  - RR mode: the first requester at or after the rr pointer wins, wrapping modulo NUMM.
  - The winner is registered into gnt_o at the clock edge, so there is 1 cycle of arbitration latency. No request: stay in IDLE.
- GRANT:
  - The granted master holds the bus until its cyc drops, including multi-beat/locked cycles.
  - When cyc drops (cyc=0 sampled): go to IDLE, clear gnt_o, and set rr pointer to (granted index + 1) mod NUMM.
  - Re-arbitration therefore takes 1 idle cycle.
  - A request from another master during GRANT waits; it is never dropped.
- Decode, combinational on the granted master's adr:
  - Slave j hits when (adr - BASE_ADDR[j]) < SIZE[j], using 32-bit unsigned subtract so wrap-around is excluded.
  - If regions overlap, the lowest j wins.
- Forwarding, only in GRANT:
  - adr, dat_m, we, sel go to all slaves.
  - cyc goes to all slaves.
  - stb goes only to the hit slave.
  - The hit slave's ack, err and dat_s return combinationally to the granted master (0 added latency).
  - Non-granted masters see ack=err=0 and dat_s=0.
- Unmapped access (cyc & stb & no hit, in GRANT):
  - err is registered and asserted to the master for exactly 1 cycle, 1 cycle after stb is sampled.
  - Re-arm rule: err_q <= stb & cyc & nohit & ~err_q, so a held stb yields alternating err pulses.
  - No slave stb is asserted.
- Watchdog (TIMEOUT>0):
  - The counter increments each cycle that a hit slave has stb=1 with no ack/err.
  - It clears on ack, err, stb=0, or leaving GRANT.
  - When the counter reaches TIMEOUT-1 with no response that cycle: on the next cycle assert err to the master and tmo_o for 1 cycle, force the slave stb low for that cycle, and clear the counter.
  - A slave ack arriving in the same cycle as the watchdog err is ignored; err takes precedence toward the master.
- Slave ack/err while its stb=0: ignored, not forwarded.
- Counter width: $clog2(TIMEOUT+1); it saturates and never wraps.
- rst asserted mid-transaction: everything returns to reset values immediately; no response is delivered.

Test Plan:
- Single master: wbm[0] writes 0xDEADBEEF to 0x10000000 (GPIO0) -> gnt_o=01 the cycle after cyc; only wbs[1].stb=1; ack returns in the same cycle as the slave ack; read-back returns 0xDEADBEEF.
- Contention, ARB_MODE=1: both masters hold cyc continuously, each doing 1 access per tenure -> grants alternate 01,10,01,10 with 1 IDLE cycle between tenures.
- Contention, ARB_MODE=0: same stimulus -> master 0 is granted every tenure while it requests; master 1 is granted only once master 0 drops cyc.
- Unmapped read at 0x20000000 -> err=1 for exactly 1 cycle, 1 cycle after stb; no wbs stb asserted; dat_s=0.
- Hung slave, TIMEOUT=8: slave never acks -> err and tmo_o pulse exactly 8 cycles after stb; slave stb=0 in the err cycle.
- Reset asserted in the middle of a GRANT-state access -> gnt_o=0, all stb/ack/err=0 asynchronously; after release, the first request is granted to master 0 (rr pointer=0).
